// File: rtl/cp0_unit_pkg.sv
// Shared CPU definitions: CP0 register numbers, exception codes and the
// SR/Cause field layout used by the coprocessor-0 block.
package cpu_defs;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    localparam sr_t    SR_RESET    = '{im: 6'd0, exl: 1'b0, ie: 1'b0};
    localparam cause_t CAUSE_RESET = '{bd: 1'b0, ip: 6'd0, exc_code: 5'd0};

    // Architectural 32-bit views; unimplemented bits read as zero.
    function automatic logic [31:0] sr_word(input sr_t s);
        logic [31:0] w;
        w = 32'd0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL_BIT]        = s.exl;
        w[SR_IE_BIT]         = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(input cause_t c);
        logic [31:0] w;
        w = 32'd0;
        w[CAUSE_BD_BIT]                = c.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]     = c.ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO]   = c.exc_code;
        return w;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_int_arbiter.sv
// Decides whether the M-stage instruction is preempted by an interrupt or
// an exception, and which ExcCode gets recorded in Cause.
module cp0_int_arbiter (
    input  logic [5:0] i_hw_int,
    input  logic [5:0] i_sr_im,
    input  logic       i_sr_ie,
    input  logic       i_sr_exl,
    input  logic [4:0] i_exc_code,
    output logic       o_int_pend,
    output logic       o_exc_pend,
    output logic       o_int_req,
    output logic [4:0] o_exc_code_sel
);
    import cpu_defs::*;

    logic w_any_unmasked;

    assign w_any_unmasked = |(i_hw_int & i_sr_im);

    // EXL masks both sources, so a handler is never re-entered.
    assign o_int_pend = w_any_unmasked & i_sr_ie & ~i_sr_exl;
    assign o_exc_pend = (i_exc_code != 5'd0) & ~i_sr_exl;
    assign o_int_req  = o_int_pend | o_exc_pend;

    // A pending interrupt outranks a simultaneous synchronous exception.
    assign o_exc_code_sel = o_int_pend ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId state, exception entry and eret return
// for the 5-stage pipeline. int_req and rd_data are combinational.
module cp0_unit #(
    parameter logic [31:0] PRID      = 32'h0000_2019,
    parameter logic [31:0] EPC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        int_req,
    output logic [31:0] epc,
    output logic [31:0] rd_data
);
    import cpu_defs::*;

    sr_t         r_sr;
    cause_t      r_cause;
    logic [31:0] r_epc;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_int_req;
    logic [4:0]  w_exc_code_sel;
    logic [31:0] w_victim_epc;
    logic        w_wr_sr;
    logic        w_wr_epc;

    cp0_int_arbiter u_arbiter (
        .i_hw_int       (hw_int),
        .i_sr_im        (r_sr.im),
        .i_sr_ie        (r_sr.ie),
        .i_sr_exl       (r_sr.exl),
        .i_exc_code     (exc_code_in),
        .o_int_pend     (w_int_pend),
        .o_exc_pend     (w_exc_pend),
        .o_int_req      (w_int_req),
        .o_exc_code_sel (w_exc_code_sel)
    );

    // A delay-slot victim restarts at its branch, one word earlier.
    assign w_victim_epc = word_align(bd ? (pc - 32'd4) : pc);

    assign w_wr_sr  = we && (wr_addr == CP0_SR);
    assign w_wr_epc = we && (wr_addr == CP0_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr    <= SR_RESET;
            r_cause <= CAUSE_RESET;
            r_epc   <= EPC_RESET;
        end else begin
            r_cause.ip <= hw_int;
            if (w_int_req) begin
                r_sr.exl         <= 1'b1;
                r_cause.exc_code <= w_exc_code_sel;
                r_cause.bd       <= bd;
                r_epc            <= w_victim_epc;
            end else begin
                if (w_wr_sr) begin
                    r_sr.im  <= wr_data[SR_IM_HI:SR_IM_LO];
                    r_sr.ie  <= wr_data[SR_IE_BIT];
                    r_sr.exl <= wr_data[SR_EXL_BIT] & ~eret;
                end else if (eret) begin
                    r_sr.exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= word_align(wr_data);
                end
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            CP0_SR:    rd_data = sr_word(r_sr);
            CP0_CAUSE: rd_data = cause_word(r_cause);
            CP0_EPC:   rd_data = r_epc;
            CP0_PRID:  rd_data = PRID;
            default:   rd_data = 32'd0;
        endcase
    end

    assign int_req = w_int_req;
    assign epc     = r_epc;

    // w_exc_pend is folded into w_int_req; kept for waveform visibility.
    logic w_unused;
    assign w_unused = w_exc_pend;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized
// traffic compared against a word-level reference model.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        int_req;
    logic [31:0] epc;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state, kept as architectural 32-bit words
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .we          (we),
        .pc          (pc),
        .bd          (bd),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret        (eret),
        .int_req     (int_req),
        .epc         (epc),
        .rd_data     (rd_data)
    );

    function automatic logic model_int_pend();
        return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int_pend() || ((exc_code_in != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2019;
            default: return 32'd0;
        endcase
    endfunction

    // advance the model with the current inputs, then let the clock edge pass
    task automatic tick();
        logic        req;
        logic        ipend;
        logic [31:0] code;
        req   = model_req();
        ipend = model_int_pend();
        if (reset) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'h0000_3000;
        end else begin
            if (req) begin
                code    = ipend ? 32'd0 : 32'(exc_code_in);
                m_sr    = m_sr | 32'h2;
                m_cause = (m_cause & ~32'h8000_007c) | (32'(bd) << 31) | (code << 2);
                m_epc   = (bd ? pc - 32'd4 : pc) & ~32'd3;
            end else begin
                if (we && wr_addr == 5'd12) m_sr = wr_data & 32'h0000_fc03;
                if (we && wr_addr == 5'd14) m_epc = wr_data & ~32'd3;
                if (eret) m_sr = m_sr & ~32'h2;
            end
            m_cause = (m_cause & ~32'h0000_fc00) | (32'(hw_int) << 10);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0; we = 1'b0;
        pc = 32'd0; bd = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_int_req: got %b expected 0", int_req);
        end
        n_checks++;
        if (epc !== 32'h0000_3000) begin
            n_errors++; $display("FAIL reset_epc: got %h expected 00003000", epc);
        end
        rd_addr = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'd0) begin
            n_errors++; $display("FAIL reset_sr: got %h expected 00000000", rd_data);
        end
        rd_addr = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'd0) begin
            n_errors++; $display("FAIL reset_cause: got %h expected 00000000", rd_data);
        end
        rd_addr = 5'd14; #1;
        n_checks++;
        if (rd_data !== 32'h0000_3000) begin
            n_errors++; $display("FAIL reset_rd_epc: got %h expected 00003000", rd_data);
        end
        rd_addr = 5'd15; #1;
        n_checks++;
        if (rd_data !== 32'h0000_2019) begin
            n_errors++; $display("FAIL reset_prid: got %h expected 00002019", rd_data);
        end
    endtask

    task automatic test_interrupt();
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_fc01;
        tick();
        we = 1'b0;
        rd_addr = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'h0000_fc01) begin
            n_errors++; $display("FAIL irq_sr_write: got %h expected 0000fc01", rd_data);
        end
        hw_int = 6'b000100; pc = 32'h0000_3020; #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++; $display("FAIL irq_req: got %b expected 1", int_req);
        end
        tick();
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++; $display("FAIL irq_req_after: got %b expected 0", int_req);
        end
        rd_addr = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'h0000_fc03) begin
            n_errors++; $display("FAIL irq_sr_exl: got %h expected 0000fc03", rd_data);
        end
        rd_addr = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_1000) begin
            n_errors++; $display("FAIL irq_cause: got %h expected 00001000", rd_data);
        end
        n_checks++;
        if (epc !== 32'h0000_3020) begin
            n_errors++; $display("FAIL irq_epc: got %h expected 00003020", epc);
        end
    endtask

    task automatic test_exception_bd();
        hw_int = 6'd0; eret = 1'b1; we = 1'b1; wr_addr = 5'd12; wr_data = 32'd0;
        tick();
        eret = 1'b0; we = 1'b0;
        exc_code_in = 5'd12; pc = 32'h0000_3010; bd = 1'b1; #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++; $display("FAIL exc_req: got %b expected 1", int_req);
        end
        tick();
        exc_code_in = 5'd0; bd = 1'b0;
        rd_addr = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h8000_0030) begin
            n_errors++; $display("FAIL exc_cause: got %h expected 80000030", rd_data);
        end
        n_checks++;
        if (epc !== 32'h0000_300c) begin
            n_errors++; $display("FAIL exc_epc_bd: got %h expected 0000300c", epc);
        end
    endtask

    task automatic test_priority();
        eret = 1'b1; we = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000_fc01;
        tick();
        eret = 1'b0; we = 1'b0;
        hw_int = 6'b000001; exc_code_in = 5'd10; pc = 32'h0000_3040; #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++; $display("FAIL prio_req: got %b expected 1", int_req);
        end
        tick();
        exc_code_in = 5'd0;
        rd_addr = 5'd13; #1;
        n_checks++;
        if (rd_data !== 32'h0000_0400) begin
            n_errors++; $display("FAIL prio_cause: got %h expected 00000400", rd_data);
        end
    endtask

    task automatic test_nested_eret();
        exc_code_in = 5'd4; #1;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++; $display("FAIL nested_exc_masked: got %b expected 0", int_req);
        end
        tick();
        exc_code_in = 5'd0; eret = 1'b1; #1;
        n_checks++;
        if (int_req !== 1'b0) begin
            n_errors++; $display("FAIL nested_eret_cycle: got %b expected 0", int_req);
        end
        tick();
        eret = 1'b0; #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++; $display("FAIL nested_held_irq: got %b expected 1", int_req);
        end
        tick();
    endtask

    task automatic test_write_drop();
        hw_int = 6'd0; eret = 1'b1;
        tick();
        eret = 1'b0;
        hw_int = 6'b000010; pc = 32'h0000_5008;
        we = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_4007; #1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_errors++; $display("FAIL drop_req: got %b expected 1", int_req);
        end
        tick();
        we = 1'b0; hw_int = 6'd0;
        n_checks++;
        if (epc !== 32'h0000_5008) begin
            n_errors++; $display("FAIL drop_epc: got %h expected 00005008", epc);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0; we = 1'b1; wr_addr = 5'd14; wr_data = 32'h0000_4007;
        tick();
        we = 1'b0;
        n_checks++;
        if (epc !== 32'h0000_4004) begin
            n_errors++; $display("FAIL lone_epc_write: got %h expected 00004004", epc);
        end
    endtask

    task automatic test_epc_wrap();
        exc_code_in = 5'd1; pc = 32'h0000_0002; bd = 1'b1;
        tick();
        exc_code_in = 5'd0; bd = 1'b0;
        n_checks++;
        if (epc !== 32'hffff_fffc) begin
            n_errors++; $display("FAIL epc_wrap: got %h expected fffffffc", epc);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_reset_midop();
        reset = 1'b1; exc_code_in = 5'd12; eret = 1'b1; hw_int = 6'h3f;
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'hffff_ffff;
        tick();
        idle_inputs();
        n_checks++;
        if (epc !== 32'h0000_3000) begin
            n_errors++; $display("FAIL midop_reset_epc: got %h expected 00003000", epc);
        end
        rd_addr = 5'd12; #1;
        n_checks++;
        if (rd_data !== 32'd0) begin
            n_errors++; $display("FAIL midop_reset_sr: got %h expected 00000000", rd_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            rd_addr     = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0:       wr_addr = 5'd12;
                1:       wr_addr = 5'd13;
                2:       wr_addr = 5'd14;
                3:       wr_addr = 5'd15;
                default: wr_addr = 5'($urandom_range(0, 31));
            endcase
            wr_data     = $urandom;
            we          = ($urandom_range(0, 2) == 0);
            pc          = $urandom;
            bd          = 1'($urandom_range(0, 1));
            exc_code_in = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            hw_int      = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            eret        = ($urandom_range(0, 5) == 0);
            #1;
            n_checks++;
            if (int_req !== model_req()) begin
                n_errors++; $display("FAIL rand_int_req[%0d]: got %b expected %b", i, int_req, model_req());
            end
            n_checks++;
            if (rd_data !== model_rd(rd_addr)) begin
                n_errors++; $display("FAIL rand_rd_data[%0d] addr %0d: got %h expected %h", i, rd_addr, rd_data, model_rd(rd_addr));
            end
            n_checks++;
            if (epc !== m_epc) begin
                n_errors++; $display("FAIL rand_epc[%0d]: got %h expected %h", i, epc, m_epc);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'h0000_3000;
        @(negedge clk);
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_priority();
        test_nested_eret();
        test_write_drop();
        test_epc_wrap();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block for the 5-stage MIPS pipeline.
- Consumes the M-stage exception code delivered by the per-stage ExcCode pipeline registers, plus the victim PC, branch-delay flag and external hardware interrupts.
- Decides whether to take an interrupt or exception, and holds SR/Cause/EPC/PRId.
- Drives int_req (pipeline flush, PC redirect to handler) and epc (eret target).

Parameters:
- PRID, 32'h0000_2019, constant value returned for reads of register 15.
- EPC_RESET, 32'h0000_3000, EPC value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_addr  in  5  CP0 register number for mfc0 read
- wr_addr  in  5  CP0 register number for mtc0 write
- wr_data  in  32  mtc0 data
- we  in  1  mtc0 write enable (M stage)
- pc  in  32  PC of the M-stage instruction
- bd  in  1  M-stage instruction sits in a branch delay slot
- exc_code_in  in  5  M-stage exception code; 0 means no exception
- hw_int  in  6  external interrupt lines, level-sensitive
- eret  in  1  M-stage instruction is eret
- int_req  out  1  take exception/interrupt this cycle (combinational)
- epc  out  32  current EPC
- rd_data  out  32  mfc0 read data (combinational)

Behaviour:
- Reset values (clk edge with reset=1):
  - SR.IM[15:10]=0, SR.EXL[1]=0, SR.IE[0]=0.
  - Cause all 0.
  - EPC=EPC_RESET.
  - Effect on outputs: int_req=0, epc=EPC_RESET.
- Register map:
  - 12 = SR: bits 15:10, 1, 0 stored; others read 0.
  - 13 = Cause: BD[31], IP[15:10], ExcCode[6:2]; others read 0.
  - 14 = EPC.
  - 15 = PRId.
  - Any other address reads 0.
- int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_pend = (exc_code_in != 0) & ~SR.EXL.
- int_req = int_pend | exc_pend, combinational, same cycle as inputs.
- On the clk edge when int_req=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= int_pend ? 5'd0 : exc_code_in. Interrupt has priority over a simultaneous exception.
  - Cause.BD <= bd.
  - EPC <= (bd ? pc-4 : pc) with bits [1:0] forced to 0. The subtraction wraps modulo 2^32.
  - mtc0 in the same cycle is discarded.
  - eret in the same cycle is ignored, so EXL still sets.
- Else, if eret=1: SR.EXL <= 0. A same-cycle mtc0 still applies, except that its EXL bit is overridden to 0.
- Else, if we=1:
  - wr_addr 12 updates IM/EXL/IE.
  - wr_addr 14 updates EPC with [1:0] forced to 0.
  - wr_addr 13 and 15 are ignored; Cause is software read-only in this design.
- Cause.IP <= hw_int every cycle, regardless of EXL/IE and of int_req.
- rd_data is combinational from the current register values. No write-to-read bypass: a same-cycle mtc0 is visible next cycle.
- Latency: int_req is 0-cycle. State updates are visible 1 cycle after the edge.
- Nested: while EXL=1, int_req=0 regardless of hw_int or exc_code_in.
- Reset mid-operation: reset wins over int_req, eret and we in the same edge.

Decomposition:
- Shared package cpu_defs holds:
  - CP0 register numbers: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - Exception codes: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - SR/Cause bit-position constants.
- Natural sub-module: cp0_int_arbiter, the combinational int_pend/exc_pend/priority and ExcCode select. Registers stay in cp0_unit.

Test Plan:
- Reset, then read addr 12/13/14/15 -> rd_data 0, 0, 32'h3000, 32'h2019; int_req=0.
- mtc0 SR=32'h0000_fc01, hold hw_int=6'b000100 -> int_req=1 on the cycle hw_int rises. Next cycle: SR.EXL=1, Cause=32'h0000_1000, EPC=pc; int_req then 0.
- exc_code_in=12, pc=32'h3010, bd=1, SR.IE=0 -> int_req=1. Then EPC=32'h300c, Cause.BD=1, Cause.ExcCode=12 (read 32'h8000_0030 with hw_int=0).
- hw_int=6'b000001 and exc_code_in=10 simultaneously, IM=6'h3f, IE=1 -> Cause.ExcCode=0 (interrupt wins).
- With EXL=1, exc_code_in=4 -> int_req=0. Then eret -> EXL=0 next cycle, and a held hw_int raises int_req.
- we=1, wr_addr=14, wr_data=32'h4007 with int_req=1 the same cycle -> write dropped, EPC=victim pc. Then a lone write of 32'h4007 -> EPC=32'h4004.
